// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: command-driven sequencer owning a WIDTH-bit Johnson ring.
// Commands (valid/ready): RUN_N steps the ring N times then pulses done,
// RUN_FREE steps until STOP/CLEAR, STOP freezes the ring, CLEAR zeroes it.
// Optional build macro: JOHNSON_SELF_CORRECT_EN
//   defined   -> illegal ring codes are detected and forced back to 0 with an err pulse
//   undefined -> no checking, err is constant 0
//
// state      | meaning
// S_IDLE     | ring held, waiting for a command
// S_RUN_N    | stepping once per edge, counting down the requested steps
// S_RUN_FREE | stepping once per edge until STOP or CLEAR
// S_DONE     | one-cycle completion state, done high, commands refused
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  localparam int PH_W = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] q,
  output logic [PH_W-1:0]  phase,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] OP_RUN_N    = 2'b00;
  localparam logic [1:0] OP_RUN_FREE = 2'b01;
  localparam logic [1:0] OP_STOP     = 2'b10;
  localparam logic [1:0] OP_CLEAR    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN_N    = 2'd1,
    S_RUN_FREE = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   q_r;
  logic [CNT_W-1:0]   cnt;
  logic               busy_r;
  logic               done_r;
  logic               ready_r;
  logic               err_r;

  logic               accept;
  logic [WIDTH-1:0]   q_step;
  logic               illegal;
  logic [PH_W:0]      ones;
  logic [PH_W:0]      ph_wide;

  assign accept = cmd_valid && ready_r;
  assign q_step = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};

`ifdef JOHNSON_SELF_CORRECT_EN
  // A legal Johnson code has at most one boundary between adjacent bits;
  // the boundary vector must therefore be zero or a single one-hot bit.
  logic [WIDTH-2:0] edges;
  assign edges   = q_r[WIDTH-1:1] ^ q_r[WIDTH-2:0];
  assign illegal = (edges & (edges - 1'b1)) != '0;
`else
  assign illegal = 1'b0;
`endif

  // Phase decode: rising half counts ones, falling half counts down from 2*WIDTH.
  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + {{PH_W{1'b0}}, q_r[i]};
    end
    if (q_r[WIDTH-1]) begin
      ph_wide = (PH_W + 1)'(2 * WIDTH) - ones;
    end else begin
      ph_wide = ones;
    end
  end

  // Sequencer FSM with registered ring, counter and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      q_r     <= '0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (illegal) begin
        // Recovery outranks any command accepted on this edge.
        state   <= S_IDLE;
        q_r     <= '0;
        cnt     <= '0;
        busy_r  <= 1'b0;
        ready_r <= 1'b1;
        err_r   <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              case (cmd_op)
                OP_RUN_N: begin
                  if (cmd_count == '0) begin
                    state   <= S_DONE;
                    done_r  <= 1'b1;
                    ready_r <= 1'b0;
                  end else begin
                    state  <= S_RUN_N;
                    cnt    <= cmd_count;
                    busy_r <= 1'b1;
                  end
                end
                OP_RUN_FREE: begin
                  state  <= S_RUN_FREE;
                  busy_r <= 1'b1;
                end
                OP_CLEAR: begin
                  q_r <= '0;
                  cnt <= '0;
                end
                default: ;
              endcase
            end
          end

          S_RUN_N: begin
            if (accept && cmd_op == OP_STOP) begin
              state  <= S_IDLE;
              cnt    <= '0;
              busy_r <= 1'b0;
            end else if (accept && cmd_op == OP_CLEAR) begin
              state  <= S_IDLE;
              q_r    <= '0;
              cnt    <= '0;
              busy_r <= 1'b0;
            end else begin
              // Run commands arriving here are consumed without effect.
              q_r <= q_step;
              cnt <= cnt - 1'b1;
              if (cnt == CNT_W'(1)) begin
                state   <= S_DONE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                ready_r <= 1'b0;
              end
            end
          end

          S_RUN_FREE: begin
            if (accept && cmd_op == OP_STOP) begin
              state  <= S_IDLE;
              busy_r <= 1'b0;
            end else if (accept && cmd_op == OP_CLEAR) begin
              state  <= S_IDLE;
              q_r    <= '0;
              cnt    <= '0;
              busy_r <= 1'b0;
            end else begin
              q_r <= q_step;
            end
          end

          S_DONE: begin
            state   <= S_IDLE;
            ready_r <= 1'b1;
          end

          default: begin
            state   <= S_IDLE;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
          end
        endcase
      end
    end
  end

  assign q         = q_r;
  assign phase     = ph_wide[PH_W-1:0];
  assign busy      = busy_r;
  assign done      = done_r;
  assign cmd_ready = ready_r;
  assign err       = err_r;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Testbench for johnson_seq_ctrl (WIDTH=4, CNT_W=8): vector tables fed through
// a scoreboard queue, plus hand-written reset and illegal-code sequences.
module tb_johnson_seq_ctrl;

  localparam int W  = 4;
  localparam int CW = 8;
  localparam int PW = 3;

  localparam logic [1:0] RN = 2'b00;
  localparam logic [1:0] RF = 2'b01;
  localparam logic [1:0] ST = 2'b10;
  localparam logic [1:0] CL = 2'b11;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic [W-1:0]  q;
  logic [PW-1:0] phase;
  logic          busy;
  logic          done;
  logic          err;

  johnson_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .q         (q),
    .phase     (phase),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [1:0]    op;
    logic [CW-1:0] cnt;
    logic [W-1:0]  q;
    logic [PW-1:0] ph;
    logic          ph_chk;
    logic          busy;
    logic          done;
    logic          rdy;
    logic          err;
  } vec_t;

  vec_t          tbl[$];
  vec_t          sbq[$];
  logic [W-1:0]  seq [8];
  int            n_vec;
  int            n_bad;

  function automatic vec_t mk(input logic v, input logic [1:0] op, input int cnt,
                              input int idx, input logic b, input logic d, input logic r);
    vec_t e;
    e.v      = v;
    e.op     = op;
    e.cnt    = CW'(cnt);
    e.q      = seq[idx % 8];
    e.ph     = PW'(idx % 8);
    e.ph_chk = 1'b1;
    e.busy   = b;
    e.done   = d;
    e.rdy    = r;
    e.err    = 1'b0;
    return e;
  endfunction

  function automatic void add(input logic v, input logic [1:0] op, input int cnt,
                              input int idx, input logic b, input logic d, input logic r);
    tbl.push_back(mk(v, op, cnt, idx, b, d, r));
  endfunction

  task automatic compare(input string name, input vec_t e);
    n_vec++;
    if (q !== e.q || (e.ph_chk && phase !== e.ph) || busy !== e.busy ||
        done !== e.done || cmd_ready !== e.rdy || err !== e.err) begin
      n_bad++;
      $display("FAIL %s #%0d: got q=%b ph=%0d busy=%b done=%b rdy=%b err=%b, want q=%b ph=%0d busy=%b done=%b rdy=%b err=%b",
               name, n_vec, q, phase, busy, done, cmd_ready, err,
               e.q, e.ph, e.busy, e.done, e.rdy, e.err);
    end
  endtask

  task automatic apply(input string name, input vec_t e);
    vec_t got;
    cmd_valid = e.v;
    cmd_op    = e.op;
    cmd_count = e.cnt;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_count = '0;
    got = sbq.pop_front();
    compare(name, got);
  endtask

  task automatic run_tbl(input string name);
    foreach (tbl[i]) apply(name, tbl[i]);
    tbl.delete();
  endtask

  initial begin
    vec_t e;
    seq[0] = 4'b0000; seq[1] = 4'b0001; seq[2] = 4'b0011; seq[3] = 4'b0111;
    seq[4] = 4'b1111; seq[5] = 4'b1110; seq[6] = 4'b1100; seq[7] = 4'b1000;
    n_vec = 0;
    n_bad = 0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_count = '0;
    rst_n     = 1'b1;

    // Asynchronous reset mid-clock, then idle.
    #2 rst_n = 1'b0;
    #1 compare("reset_async", mk(0, RN, 0, 0, 0, 0, 1));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) add(0, RN, 0, 0, 0, 0, 1);
    run_tbl("idle_after_reset");

    // RUN_N 5 from 0000.
    add(1, RN, 5, 0, 1, 0, 1);
    for (int i = 1; i <= 4; i++) add(0, RN, 0, i, 1, 0, 1);
    add(0, RN, 0, 5, 0, 1, 0);
    add(0, RN, 0, 5, 0, 0, 1);
    run_tbl("run_n5");

    // CLEAR, full-ring RUN_N 8, then RUN_N 0.
    add(1, CL, 0, 0, 0, 0, 1);
    add(1, RN, 8, 0, 1, 0, 1);
    for (int i = 1; i <= 7; i++) add(0, RN, 0, i, 1, 0, 1);
    add(0, RN, 0, 8, 0, 1, 0);
    add(0, RN, 0, 8, 0, 0, 1);
    add(1, RN, 0, 0, 0, 1, 0);
    add(0, RN, 0, 0, 0, 0, 1);
    run_tbl("run_n8_n0");

    // RUN_N 10 wraps past 2*WIDTH to index 2.
    add(1, RN, 10, 0, 1, 0, 1);
    for (int i = 1; i <= 9; i++) add(0, RN, 0, i, 1, 0, 1);
    add(0, RN, 0, 10, 0, 1, 0);
    add(0, RN, 0, 10, 0, 0, 1);
    add(1, CL, 0, 0, 0, 0, 1);
    run_tbl("run_n10_wrap");

    // RUN_FREE, STOP after 11 steps, STOP in IDLE.
    add(1, RF, 0, 0, 1, 0, 1);
    for (int i = 1; i <= 11; i++) add(0, RN, 0, i, 1, 0, 1);
    add(1, ST, 0, 11, 0, 0, 1);
    add(0, RN, 0, 11, 0, 0, 1);
    add(0, RN, 0, 11, 0, 0, 1);
    add(1, ST, 0, 11, 0, 0, 1);
    add(0, RN, 0, 11, 0, 0, 1);
    run_tbl("free_stop");

    // RUN_N 20 from index 3 with ignored run commands, CLEAR at step 6.
    add(1, RN, 20, 3, 1, 0, 1);
    for (int s = 1; s <= 6; s++) begin
      if (s == 3)      add(1, RN, 3, 3 + s, 1, 0, 1);
      else if (s == 5) add(1, RF, 0, 3 + s, 1, 0, 1);
      else             add(0, RN, 0, 3 + s, 1, 0, 1);
    end
    add(1, CL, 0, 0, 0, 0, 1);
    add(0, RN, 0, 0, 0, 0, 1);
    add(0, RN, 0, 0, 0, 0, 1);
    run_tbl("run_n20_clear");

    // RUN_N 20 with async reset at step 6.
    add(1, RN, 20, 0, 1, 0, 1);
    for (int s = 1; s <= 6; s++) add(0, RN, 0, s, 1, 0, 1);
    run_tbl("run_n20_pre_reset");
    #2 rst_n = 1'b0;
    #1 compare("reset_midrun", mk(0, RN, 0, 0, 0, 0, 1));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) add(0, RN, 0, 0, 0, 0, 1);
    run_tbl("idle_after_midrun_reset");

`ifdef JOHNSON_SELF_CORRECT_EN
    // Illegal code in IDLE is corrected on the next edge with an err pulse.
    #2 force dut.q_r = 4'b0101;
    #1 release dut.q_r;
    e = mk(0, RN, 0, 0, 0, 0, 1);
    e.err = 1'b1;
    apply("illegal_corrected", e);
    apply("illegal_err_clears", mk(0, RN, 0, 0, 0, 0, 1));
    // Correction outranks a RUN_FREE accepted on the same edge.
    #2 force dut.q_r = 4'b1001;
    #1 release dut.q_r;
    e = mk(1, RF, 0, 0, 0, 0, 1);
    e.err = 1'b1;
    apply("illegal_vs_cmd", e);
    apply("illegal_vs_cmd_after", mk(0, RN, 0, 0, 0, 0, 1));
`else
    // Without correction an illegal code keeps shifting by the step rule.
    apply("free_for_illegal", mk(1, RF, 0, 0, 1, 0, 1));
    #2 force dut.q_r = 4'b0101;
    #1 release dut.q_r;
    e = mk(0, RN, 0, 0, 1, 0, 1);
    e.q = 4'b1011;
    e.ph_chk = 1'b0;
    apply("illegal_orbit_1", e);
    e.q = 4'b0110;
    apply("illegal_orbit_2", e);
    apply("illegal_clear", mk(1, CL, 0, 0, 0, 0, 1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
